// File: rtl/conv3x3_wt_mac_pkg.sv
// Shared widths, FSM state type and tap extraction for the 3x3 weight MAC.
`timescale 1ns/1ps
package conv_mac_pkg;
    localparam int TAPS     = 9;
    localparam int W_BITS   = 16;
    localparam int ACC_BITS = 36;
    localparam int P_BITS   = 2 * W_BITS;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    function automatic logic signed [W_BITS-1:0] tap(input logic [TAPS*W_BITS-1:0] word, input int i);
        return word[W_BITS*i +: W_BITS];
    endfunction
endpackage

// File: rtl/conv3x3_wt_mac_dot9_pipe.sv
// Two-stage 9-tap signed dot product: registered products, then registered adder tree.
// Optional CONV_MAC_RELU_EN clamps negative results to zero in the final register.
`timescale 1ns/1ps
module dot9_pipe
    import conv_mac_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_mul,
    input  logic                       en_sum,
    input  logic [TAPS*W_BITS-1:0]     win,
    input  logic [TAPS*W_BITS-1:0]     q,
    output logic [ACC_BITS-1:0]        result
);
    logic signed [P_BITS-1:0]   prod [TAPS];
    logic signed [ACC_BITS-1:0] sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) prod[i] <= '0;
        end else if (en_mul) begin
            for (int i = 0; i < TAPS; i++) prod[i] <= tap(win, i) * tap(q, i);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) sum = sum + ACC_BITS'(prod[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
        end else if (en_sum) begin
`ifdef CONV_MAC_RELU_EN
            result <= sum[ACC_BITS-1] ? '0 : sum;
`else
            result <= sum;
`endif
        end
    end
endmodule

// File: rtl/conv3x3_wt_mac.sv
// Window x weight-ROM MAC: walks the dual-port ROM two kernels per cycle and emits two dot products.
// Build option CONV_MAC_RELU_EN enables zero-clamping of negative results (see dot9_pipe).
`timescale 1ns/1ps
// state | meaning
// IDLE  | win_ready high, waiting for a window
// FETCH | presenting one kernel address pair per cycle
// DRAIN | waiting for the 3-stage pipeline to empty
// DONE  | one-cycle done pulse
module conv3x3_wt_mac
    import conv_mac_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 144,
    parameter int DEPTH      = 76
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [DATA_WIDTH-1:0] win_data,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [5:0]            num_pairs,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  out_valid,
    output logic [5:0]            out_idx,
    output logic [ACC_BITS-1:0]   out_a,
    output logic [ACC_BITS-1:0]   out_b,
    output logic                  done
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO     = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0] THREE   = (ADDR_WIDTH+1)'(3);

    state_t                state;
    logic [DATA_WIDTH-1:0] win_q;
    logic [5:0]            num_q;
    logic [5:0]            k;
    logic                  v1, v2;
    logic [5:0]            idx1, idx2;

    // Inputs are at most DEPTH+2, so a single conditional subtract wraps them.
    function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [ADDR_WIDTH:0] a);
        logic [ADDR_WIDTH:0] r;
        r = (a >= DEPTH_W) ? a - DEPTH_W : a;
        return r[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_q     <= '0;
            num_q     <= '0;
            k         <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            win_ready <= 1'b0;
            done      <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            idx1      <= '0;
            idx2      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            v1        <= (state == FETCH);
            idx1      <= k;
            v2        <= v1;
            idx2      <= idx1;
            out_valid <= v2;
            if (v2) out_idx <= idx2;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid && win_ready) begin
                        win_q     <= win_data;
                        num_q     <= num_pairs;
                        k         <= '0;
                        addr_a    <= base_addr;
                        addr_b    <= wrap({1'b0, base_addr} + ONE);
                        win_ready <= 1'b0;
                        if (num_pairs == 6'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        win_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (k == num_q - 6'd1) begin
                        state <= DRAIN;
                    end else begin
                        k      <= k + 6'd1;
                        addr_a <= wrap({1'b0, addr_a} + TWO);
                        addr_b <= wrap({1'b0, addr_a} + THREE);
                    end
                end
                DRAIN: begin
                    if (!v1 && !v2) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    win_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dot9_pipe u_lane_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_mul (v1),
        .en_sum (v2),
        .win    (win_q),
        .q      (q_a),
        .result (out_a)
    );

    dot9_pipe u_lane_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_mul (v1),
        .en_sum (v2),
        .win    (win_q),
        .q      (q_b),
        .result (out_b)
    );
endmodule

// File: doc/conv3x3_wt_mac.md
Name: conv3x3_wt_mac

Overview:
- Downstream consumer of the dual-port 3x3 weight ROM (76 words x 144 bits, nine signed 16-bit taps per word).
- Accepts one 3x3 pixel window, then walks the ROM two kernels per cycle: port a reads the even kernel, port b reads the odd kernel.
- Produces two full-precision 9-tap dot products per cycle.
- Feeds the activation/pooling stage of the MNIST conv layer.

Parameters:
ADDR_WIDTH, 7, ROM address width
DATA_WIDTH, 144, ROM word / window width (TAPS*W_BITS)
DEPTH, 76, ROM entries; addresses wrap modulo DEPTH
TAPS, 9, taps per kernel
W_BITS, 16, signed tap / pixel width
ACC_BITS, 36, signed result width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
win_valid  in  1  window offered
win_ready  out  1  block can accept a window
win_data  in  DATA_WIDTH  pixel i at bits [16i+15:16i], i=0..8
base_addr  in  ADDR_WIDTH  first kernel address, sampled on accept
num_pairs  in  6  kernel pairs to compute (0..38), sampled on accept
addr_a  out  ADDR_WIDTH  ROM port a address (registered)
addr_b  out  ADDR_WIDTH  ROM port b address (registered)
q_a  in  DATA_WIDTH  ROM port a data, 1-cycle read latency
q_b  in  DATA_WIDTH  ROM port b data
out_valid  out  1  results valid
out_idx  out  6  pair index k of current results
out_a  out  ACC_BITS  signed dot(window, kernel base+2k)
out_b  out  ACC_BITS  signed dot(window, kernel base+2k+1)
done  out  1  one-cycle pulse after last result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, rst_n.
- Reset values: state IDLE; win_ready, out_valid and done = 0; addr_a, addr_b, out_idx, out_a and out_b = 0; pipeline valids cleared.
- Reset asserted mid-operation aborts the operation: no further out_valid, no done.
- FSM has four states: IDLE, FETCH, DRAIN, DONE.
- IDLE: win_ready=1. Accept when win_valid&&win_ready (cycle 0). On accept, latch win_data, base_addr and num_pairs.
  - num_pairs==0 -> DONE.
  - otherwise -> FETCH.
- FETCH: runs for cycles 1..N, one pair per cycle.
  - Cycle 1+k: addr_a = (base+2k) mod DEPTH, addr_b = (base+2k+1) mod DEPTH.
  - Address pointer increments by 2 and wraps past DEPTH-1.
  - After pair N-1 -> DRAIN.
- DRAIN: wait until the pipeline is empty -> DONE.
- DONE: done=1, win_ready=0 for one cycle -> IDLE.
- Pipeline, 3 cycles from address to result:
  - address registered;
  - ROM q returned;
  - 9 signed 16x16 products registered (32-bit);
  - sign-extended adder tree registered into ACC_BITS.
- Timing: results for pair k appear at cycle 4+k with out_idx=k. The last result is at cycle N+3, done at N+4, win_ready high again at N+5. For num_pairs==0, done is at cycle 1.
- Throughput: one pair per cycle. No output backpressure; the consumer must accept every out_valid cycle.
- win_valid asserted outside IDLE is ignored (win_ready=0).
- Arithmetic: full precision, no saturation or rounding. The worst case |9*2^30| fits 36 bits.
- num_pairs > 38 is legal; addresses simply keep wrapping.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- Defined: out_a and out_b are replaced by 0 when negative, inside the final register stage; latency unchanged.
- Undefined: signed results pass through unmodified.

Decomposition:
- Package conv_mac_pkg holds:
  - width constants (TAPS, W_BITS, ACC_BITS);
  - state enum type;
  - function tap(word,i) returning signed [15:0].
- Sub-module dot9_pipe: 2-stage multiply + adder tree, instantiated twice (lanes a and b). The top holds the FSM and address generation.

Test Plan:
All scenarios use a bench ROM model where mem[i] has all taps = i+1 and 1-cycle read latency.
- Single pair: pixels all 2, base 0, num_pairs 1 -> cycle 4 out_a=18, out_b=36, out_idx=0; done cycle 5; win_ready cycle 6.
- Full sweep: pixels all 2, base 0, num_pairs 38 -> pair k out_a=18(2k+1), out_b=18(2k+2), consecutive cycles 4..41; done cycle 42.
- Wrap: base 75, num_pairs 2 -> address pairs (75,0) then (1,2); out_a=1368 then 36, out_b=18 then 54.
- Zero pairs: num_pairs 0 -> done cycle 1, out_valid never asserted.
- Extremes, using a bench ROM with all taps 16'h8000:
  - pixels 16'h8000 -> out = 9663676416.
  - pixels 16'h7FFF -> out = -9663381504; with CONV_MAC_RELU_EN -> 0.
- Reset mid-FETCH: rst_n low in cycle 3 with num_pairs 10 -> all outputs 0 next cycle, no done; after release, win_ready=1 and a new window is accepted normally.
